i_type_lsu: RTL and testbench
=============================

// Module: i_type_lsu
// PURPOSE
//  Parametrised multi-cycle I-type execute/load-store unit. Holds a GPR file and a
//  byte-addressed data memory, decodes MIPS I-type opcodes and sign/zero-extends imm.
//  Forms rs+imm for loads/stores, or the ALU result for immediate ops, and writes back.
//  Sits behind the decoder; one instruction in flight, valid/ready handshake.
// PARAMETERS
//  DATA_W    32  datapath width (must be 32; byte lanes assume 4 bytes/word)
//  NREGS     32  GPR count; register index width = clog2(NREGS)
//  MEM_WORDS 32  data memory depth in words; word index = addr[clog2(MEM_WORDS)+1:2]
//  MEM_LAT   1   extra wait cycles in MEM state (0..7)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active low
//  in_valid   in   1       instruction present on opcode/rs/rt/imm
//  in_ready   out  1       unit idle, accepts instruction this cycle
//  opcode     in   6       I-type opcode
//  rs, rt     in   RW      source/target register index
//  imm        in   16      immediate
//  done       out  1       1-cycle pulse: instruction retired (incl. faults)
//  fault      out  1       valid with done: misaligned access, no state changed
//  result     out  DATA_W  ALU result or effective address of retired instr
//  datars     out  DATA_W  combinational GPR[rs] read
//  datart     out  DATA_W  combinational GPR[rt] read
// BEHAVIOUR
//  Reset: in_ready=1, done=0, fault=0, result=0; GPR[i]=i (GPR[0]=0); MEM word i=i.
//  FSM IDLE->EXEC->MEM->WB->IDLE. IDLE: in_ready=1; in_valid&in_ready latches
//   opcode/rs/rt/imm -> EXEC. Inputs ignored outside IDLE.
//  EXEC: compute result; non-memory ops and unknown opcodes go straight to WB.
//  MEM: waits MEM_LAT cycles (counter), then reads or writes memory -> WB.
//  WB: GPR write, done=1 for this cycle -> IDLE. Latency accept->done: 3+MEM_LAT
//   cycles for memory ops, 2 cycles otherwise.
//  Ops: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000,
//   SH 101001, SW 101011 (addr=GPR[rs]+sext(imm)); ADDI 001000, ADDIU 001001
//   (+sext), SLTI 001010 (signed <), ANDI 001100, ORI 001101 (zext),
//   LUI 001111 (imm<<16). Others: no write, done pulses, fault=0.
//  Arithmetic mod 2^32; ADDI overflow not trapped (same as ADDIU).
//  Little-endian lanes: byte lane=addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend;
//   SB/SH modify only their lanes (read-modify-write of the word).
//  Misaligned (LW/SW addr[1:0]!=0, LH/LHU/SH addr[0]!=0): skip MEM access and
//   writeback, done=1 with fault=1, result=address.
//  Word index beyond MEM_WORDS wraps modulo MEM_WORDS (upper addr bits ignored).
//  Writes to GPR[0] are discarded; reads of GPR[0] return 0.
//  Store data = GPR[rt] sampled in MEM; WB of a load to rt is visible on datart the
//   cycle after done.
//  rst_n low at any state: FSM to IDLE at once, in-flight instr dropped, arrays re-init.
// STRUCTURE
//  Shared package i_type_pkg: opcode localparams, state enum, size/lane encoding.
//  One sub-module: i_type_ext (sign/zero/lui extend + load lane extract/sext).
//  ALU ops are inline; GPR file and memory are local arrays.
// TESTING
//  Reset: after rst_n rise, datars(rs=7)=7, in_ready=1, done=0.
//  LW rt=9,rs=2,imm=2 -> addr 4, done at cycle 4 (MEM_LAT=1), GPR[9]=1.
//  SB rt=5,rs=0,imm=0x0009 -> MEM[2]=0x00000502; LBU rt=6 addr 9 -> GPR[6]=5.
//  SW rs=1,imm=2 (addr 3) -> fault=1, result=3, memory unchanged.
//  ADDI rt=3,rs=4,imm=0xFFFF -> GPR[3]=3; SLTI rt=8,rs=1,imm=0xFFFF -> GPR[8]=0.
//  LW rt=0 -> GPR[0] stays 0; rst_n low during MEM -> in_ready=1, no done, no write.

Source files
------------

// File: rtl/i_type_pkg.sv
// Shared definitions for the I-type execute/load-store unit: opcodes, FSM states,
// access size encoding and the memory-op decode helper.
package i_type_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned ST_W  = 2;
  localparam int unsigned SZ_W_BITS = 2;

  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
  localparam logic [OP_W-1:0] OP_LHU   = 6'b100101;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH    = 6'b101001;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_EXEC = 2'd1;
  localparam logic [ST_W-1:0] S_MEM  = 2'd2;
  localparam logic [ST_W-1:0] S_WB   = 2'd3;

  localparam logic [SZ_W_BITS-1:0] SZ_B = 2'd0;
  localparam logic [SZ_W_BITS-1:0] SZ_H = 2'd1;
  localparam logic [SZ_W_BITS-1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic                 load;
    logic                 store;
    logic                 sgn;
    logic [SZ_W_BITS-1:0] size;
  } mem_op_t;

  // Non-memory opcodes decode to all-zero (byte size, no access)
  function automatic mem_op_t mem_decode(input logic [OP_W-1:0] op);
    mem_op_t m;
    m = '0;
    case (op)
      OP_LB:   m = '{load: 1'b1, store: 1'b0, sgn: 1'b1, size: SZ_B};
      OP_LH:   m = '{load: 1'b1, store: 1'b0, sgn: 1'b1, size: SZ_H};
      OP_LW:   m = '{load: 1'b1, store: 1'b0, sgn: 1'b0, size: SZ_W};
      OP_LBU:  m = '{load: 1'b1, store: 1'b0, sgn: 1'b0, size: SZ_B};
      OP_LHU:  m = '{load: 1'b1, store: 1'b0, sgn: 1'b0, size: SZ_H};
      OP_SB:   m = '{load: 1'b0, store: 1'b1, sgn: 1'b0, size: SZ_B};
      OP_SH:   m = '{load: 1'b0, store: 1'b1, sgn: 1'b0, size: SZ_H};
      OP_SW:   m = '{load: 1'b0, store: 1'b1, sgn: 1'b0, size: SZ_W};
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/i_type_ext.sv
// Immediate extension (sign, zero, LUI shift) and little-endian load lane
// extraction with sign/zero extension.
module i_type_ext
  import i_type_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]      opcode,
  input  logic [IMM_W-1:0]     imm,
  input  logic                 sgn,
  input  logic [SZ_W_BITS-1:0] size,
  input  logic [1:0]           lane,
  input  logic [DATA_W-1:0]    word,
  output logic [DATA_W-1:0]    imm_val_c,
  output logic [DATA_W-1:0]    load_val_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    imm_val_c = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (opcode)
      OP_LUI:         imm_val_c = {imm, {(DATA_W-IMM_W){1'b0}}};
      OP_ANDI, OP_ORI: imm_val_c = {{(DATA_W-IMM_W){1'b0}}, imm};
      default:        imm_val_c = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endcase
  end

  // Halfword lanes are selected by lane[1]; alignment is checked upstream
  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = word[{lane[1], 4'b0000} +: 16];
    load_val_c = word;
    case (size)
      SZ_B:    load_val_c = {{(DATA_W-8){sgn & byte_sel[7]}}, byte_sel};
      SZ_H:    load_val_c = {{(DATA_W-16){sgn & half_sel[15]}}, half_sel};
      default: load_val_c = word;
    endcase
  end

endmodule

// File: rtl/i_type_lsu.sv
// Multi-cycle I-type execute/load-store unit with local GPR file and data memory.
// One instruction in flight: IDLE -> EXEC -> (MEM) -> WB -> IDLE.
module i_type_lsu
  import i_type_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          opcode,
  input  logic [$clog2(NREGS)-1:0] rs,
  input  logic [$clog2(NREGS)-1:0] rt,
  input  logic [IMM_W-1:0]         imm,
  output logic                     done,
  output logic                     fault,
  output logic [DATA_W-1:0]        result,
  output logic [DATA_W-1:0]        datars,
  output logic [DATA_W-1:0]        datart
);

  localparam int unsigned RW    = $clog2(NREGS);
  localparam int unsigned MW    = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 3;

  logic [ST_W-1:0]   state, state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [RW-1:0]     rs_q, rt_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] load_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;

  logic [DATA_W-1:0] gpr [NREGS];
  logic [DATA_W-1:0] mem [MEM_WORDS];

  mem_op_t           mop_c;
  logic [DATA_W-1:0] rs_val_c, rt_val_c, imm_val_c, load_val_c;
  logic [DATA_W-1:0] sum_c, exec_c, st_word_c;
  logic              misalign_c, wr_c, accept_c, mem_go_c, mem_op_c;
  logic [MW-1:0]     widx_c;
  logic [1:0]        lane_c;

  assign datars = gpr[rs];
  assign datart = gpr[rt];

  // After EXEC, val_q holds the effective address for memory ops
  assign lane_c   = val_q[1:0];
  assign widx_c   = val_q[MW+1:2];
  assign accept_c = in_valid & in_ready & (state == S_IDLE);
  assign mem_go_c = (cnt_q == CNT_W'(MEM_LAT));

  i_type_ext #(
    .DATA_W(DATA_W)
  ) u_ext (
    .opcode    (op_q),
    .imm       (imm_q),
    .sgn       (mop_c.sgn),
    .size      (mop_c.size),
    .lane      (lane_c),
    .word      (load_q),
    .imm_val_c (imm_val_c),
    .load_val_c(load_val_c)
  );

  // Execute: ALU result or effective address, alignment check, writeback enable
  always_comb begin
    mop_c      = mem_decode(op_q);
    mem_op_c   = mop_c.load | mop_c.store;
    rs_val_c   = gpr[rs_q];
    rt_val_c   = gpr[rt_q];
    sum_c      = rs_val_c + imm_val_c;
    exec_c     = '0;
    wr_c       = 1'b0;
    misalign_c = ((mop_c.size == SZ_W) && (sum_c[1:0] != 2'b00)) ||
                 ((mop_c.size == SZ_H) && sum_c[0]);
    case (op_q)
      OP_ADDI, OP_ADDIU: begin exec_c = sum_c;                   wr_c = 1'b1; end
      OP_SLTI: begin
        exec_c = DATA_W'($signed(rs_val_c) < $signed(imm_val_c));
        wr_c   = 1'b1;
      end
      OP_ANDI: begin exec_c = rs_val_c & imm_val_c;              wr_c = 1'b1; end
      OP_ORI:  begin exec_c = rs_val_c | imm_val_c;              wr_c = 1'b1; end
      OP_LUI:  begin exec_c = imm_val_c;                         wr_c = 1'b1; end
      default: begin
        exec_c = mem_op_c ? sum_c : '0;
        wr_c   = mop_c.load & ~misalign_c;
      end
    endcase
  end

  // Read-modify-write merge so SB/SH touch only their lanes
  always_comb begin
    st_word_c = mem[widx_c];
    case (mop_c.size)
      SZ_B:    st_word_c[{lane_c, 3'b000} +: 8]     = rt_val_c[7:0];
      SZ_H:    st_word_c[{lane_c[1], 4'b0000} +: 16] = rt_val_c[15:0];
      default: st_word_c = rt_val_c;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (mem_op_c && !misalign_c) ? S_MEM : S_WB;
      S_MEM:   if (mem_go_c) state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      imm_q  <= '0;
      val_q  <= '0;
      load_q <= '0;
      cnt_q  <= '0;
      wr_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        op_q  <= opcode;
        rs_q  <= rs;
        rt_q  <= rt;
        imm_q <= imm;
      end
      if (state == S_EXEC) begin
        val_q <= exec_c;
        wr_q  <= wr_c;
        cnt_q <= '0;
      end
      if (state == S_MEM) begin
        if (mem_go_c) begin
          if (mop_c.load) load_q <= mem[widx_c];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Registered handshake/retire outputs; done/fault live only in WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      done     <= 1'b0;
      fault    <= 1'b0;
      result   <= '0;
    end else begin
      in_ready <= (state_nxt == S_IDLE);
      done     <= (state_nxt == S_WB);
      fault    <= (state == S_EXEC) && (state_nxt == S_WB) && misalign_c;
      if ((state != S_WB) && (state_nxt == S_WB))
        result <= (state == S_EXEC) ? exec_c : val_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) gpr[i] <= DATA_W'(i);
    end else if ((state == S_WB) && wr_q && (rt_q != '0)) begin
      gpr[rt_q] <= mop_c.load ? load_val_c : val_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] <= DATA_W'(i);
    end else if ((state == S_MEM) && mem_go_c && mop_c.store) begin
      mem[widx_c] <= st_word_c;
    end
  end

endmodule

// File: tb/tb_i_type_lsu.sv
// Randomized self-checking bench for i_type_lsu against an arithmetic reference
// model of the register file and byte-addressed memory.
module tb_i_type_lsu;

  localparam int unsigned MEM_LAT   = 1;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [15:0] imm = '0;
  logic        done;
  logic        fault;
  logic [31:0] result;
  logic [31:0] datars;
  logic [31:0] datart;

  int checks = 0;
  int errors = 0;

  logic [31:0] gpr_m [NREGS];
  logic [31:0] mem_m [MEM_WORDS];

  logic [5:0] ops [14] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                           6'b101000, 6'b101001, 6'b101011, 6'b001000, 6'b001001,
                           6'b001010, 6'b001100, 6'b001101, 6'b001111};

  i_type_lsu #(
    .DATA_W(32), .NREGS(NREGS), .MEM_WORDS(MEM_WORDS), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .imm(imm), .done(done), .fault(fault),
    .result(result), .datars(datars), .datart(datart)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) gpr_m[i] = 32'(i);
    for (int i = 0; i < int'(MEM_WORDS); i++) mem_m[i] = 32'(i);
  endtask

  // Issue one instruction, predict its effect from the ISA rules, check retirement.
  task automatic run(input logic [5:0] op, input logic [4:0] rsi, input logic [4:0] rti,
                     input logic [15:0] immi);
    logic [31:0] a, sx, addr, w, mask, raw, val, nw;
    int size, sh, widx, lat, cyc;
    bit ld, st, sgn, known, mis, wr;
    a = gpr_m[rsi];
    sx = {{16{immi[15]}}, immi};
    addr = a + sx;
    widx = int'((addr >> 2) % MEM_WORDS);
    sh = 8 * int'(addr % 4);
    w = mem_m[widx];
    ld = 0; st = 0; sgn = 0; known = 1; wr = 0; size = 0; val = 0; nw = w;
    case (op)
      6'b100000: begin ld = 1; sgn = 1; size = 1; end
      6'b100001: begin ld = 1; sgn = 1; size = 2; end
      6'b100011: begin ld = 1; size = 4; end
      6'b100100: begin ld = 1; size = 1; end
      6'b100101: begin ld = 1; size = 2; end
      6'b101000: begin st = 1; size = 1; end
      6'b101001: begin st = 1; size = 2; end
      6'b101011: begin st = 1; size = 4; end
      6'b001000, 6'b001001: begin val = a + sx; wr = 1; end
      6'b001010: begin val = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; wr = 1; end
      6'b001100: begin val = a & {16'h0, immi}; wr = 1; end
      6'b001101: begin val = a | {16'h0, immi}; wr = 1; end
      6'b001111: begin val = {immi, 16'h0}; wr = 1; end
      default: known = 0;
    endcase
    mis = (ld || st) && ((addr % size) != 0);
    if (ld || st) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
      if (ld && !mis) begin
        raw = (w >> sh) & mask;
        if (sgn && raw >= (32'h1 << (8 * size - 1))) raw = raw - (32'h1 << (8 * size));
        val = raw;
        wr = 1;
      end
      if (st && !mis) nw = (w & ~(mask << sh)) | ((gpr_m[rti] & mask) << sh);
    end
    lat = ((ld || st) && !mis) ? 3 + int'(MEM_LAT) : 2;

    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    opcode = op; rs = rsi; rt = rti; imm = immi; in_valid = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      opcode = 6'($urandom); rs = 5'($urandom); imm = 16'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("fault", 32'(fault), 32'(mis));
    if (ld || st) check("result_addr", result, addr);
    else if (known) check("result_alu", result, val);

    if (wr && !mis && rti != 0) gpr_m[rti] = val;
    if (st && !mis) mem_m[widx] = nw;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("datart_wb", datart, gpr_m[rti]);
    if (st) check("mem_word", dut.mem[widx], mem_m[widx]);
  endtask

  initial begin
    logic [5:0] op;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rs = 5'd7;
    #1;
    check("rst_datars7", datars, 32'd7);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_result", result, 32'd0);

    run(6'b100011, 5'd2, 5'd9, 16'h0002);   // LW -> GPR[9]=1
    check("lw_gpr9", gpr_m[9], 32'd1);
    run(6'b101000, 5'd0, 5'd5, 16'h0009);   // SB -> MEM[2]=0x502
    check("sb_mem2", dut.mem[2], 32'h0000_0502);
    run(6'b100100, 5'd0, 5'd6, 16'h0009);   // LBU -> 5
    run(6'b101011, 5'd1, 5'd4, 16'h0002);   // SW misaligned, addr 3
    run(6'b001000, 5'd4, 5'd3, 16'hFFFF);   // ADDI -> 3
    run(6'b001010, 5'd1, 5'd8, 16'hFFFF);   // SLTI -> 0
    run(6'b100011, 5'd0, 5'd0, 16'h0000);   // LW to r0 discarded
    run(6'b100011, 5'd0, 5'd11, 16'h0084);  // word index wraps to 1
    run(6'b001101, 5'd0, 5'd12, 16'h8000);  // ORI zero-extends
    run(6'b101001, 5'd0, 5'd12, 16'h0012);  // SH upper lane of word 4
    run(6'b100001, 5'd0, 5'd13, 16'h0012);  // LH sign-extends 0x8000
    run(6'b100001, 5'd0, 5'd13, 16'h0013);  // LH misaligned
    run(6'b111111, 5'd3, 5'd14, 16'h1234);  // unknown opcode

    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      run(op, 5'($urandom), 5'($urandom),
          ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127)));
    end

    // Reset while a load sits in MEM: dropped, arrays back to initial contents
    @(negedge clk);
    opcode = 6'b100011; rs = 5'd0; rt = 5'd10; imm = 16'h0008; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'd0);
    end
    check("post_rst_datart10", datart, 32'd10);
    run(6'b100011, 5'd0, 5'd10, 16'h0028);  // LW word 10 after re-init

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
